vram_host_port: RTL and testbench



---
 rtl/vram_pkg.sv | 22 ++
 rtl/vram_ptr_unit.sv | 50 +++++
 rtl/vram_host_port.sv | 163 ++++++++++++++++
 tb/tb_vram_host_port.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM host port: register map, status bits, FSM states.
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W = 13;

  localparam logic [2:0] REG_ADDR_LO = 3'd0;
  localparam logic [2:0] REG_ADDR_HI = 3'd1;
  localparam logic [2:0] REG_DATA    = 3'd2;
  localparam logic [2:0] REG_CNT_LO  = 3'd3;
  localparam logic [2:0] REG_CNT_HI  = 3'd4;
  localparam logic [2:0] REG_FILL_GO = 3'd5;
  localparam logic [2:0] REG_STATUS  = 3'd7;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_ERR  = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/vram_ptr_unit.sv
// VRAM address pointer with byte loads and a selectable wrap-around increment.
module vram_ptr_unit
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W   = VRAM_ADDR_W,
  parameter int unsigned INCR_ALT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_lo,
  input  logic              ld_hi,
  input  logic              adv,
  input  logic [7:0]        din,
  output logic [ADDR_W-1:0] ptr,
  output logic              incr_sel
);

  logic [ADDR_W-1:0] ptr_d, ptr_q, incr;
  logic              incr_sel_d, incr_sel_q;

  // Next pointer: byte loads or advance; the add wraps at 2^ADDR_W by truncation.
  always_comb begin
    incr       = incr_sel_q ? ADDR_W'(INCR_ALT) : ADDR_W'(1);
    ptr_d      = ptr_q;
    incr_sel_d = incr_sel_q;
    if (ld_lo) begin
      ptr_d[7:0] = din;
    end else if (ld_hi) begin
      ptr_d[ADDR_W-1:8] = din[ADDR_W-9:0];
      incr_sel_d        = din[7];
    end else if (adv) begin
      ptr_d = ptr_q + incr;
    end
  end

  // Pointer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      incr_sel_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      incr_sel_q <= incr_sel_d;
    end
  end

  assign ptr      = ptr_q;
  assign incr_sel = incr_sel_q;

endmodule

// File: rtl/vram_host_port.sv
// Host register file and write sequencer for the display VRAM write port.
module vram_host_port
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W   = VRAM_ADDR_W,
  parameter int unsigned INCR_ALT = 32,
  parameter int unsigned CNT_W    = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        hostAddr,
  input  logic [7:0]        hostWrData,
  input  logic              hostWr,
  input  logic              hostRd,
  output logic [7:0]        hostRdData,
  output logic [ADDR_W-1:0] vramWrAddr,
  output logic [7:0]        vramWrData,
  output logic              vramWr,
  output logic              busy
);

  fill_state_e       state_d, state_q;
  logic [7:0]        fill_val_d, fill_val_q;
  logic [CNT_W-1:0]  rem_d, rem_q;
  logic [CNT_W-1:0]  fill_cnt_d, fill_cnt_q;
  logic              err_d, err_q;
  logic              busy_d, busy_q;
  logic              vram_wr_d, vram_wr_q;
  logic [ADDR_W-1:0] vram_addr_d, vram_addr_q;
  logic [7:0]        vram_data_d, vram_data_q;
  logic [7:0]        rd_data_d, rd_data_q;
  logic [ADDR_W-1:0] ptr;
  logic              incr_sel;
  logic              ld_lo, ld_hi, adv;

  vram_ptr_unit #(
    .ADDR_W   (ADDR_W),
    .INCR_ALT (INCR_ALT)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .ld_lo    (ld_lo),
    .ld_hi    (ld_hi),
    .adv      (adv),
    .din      (hostWrData),
    .ptr      (ptr),
    .incr_sel (incr_sel)
  );

  // Register decode, fill sequencing and next values of all output registers.
  always_comb begin
    state_d     = state_q;
    fill_val_d  = fill_val_q;
    rem_d       = rem_q;
    fill_cnt_d  = fill_cnt_q;
    vram_wr_d   = 1'b0;
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    rd_data_d   = rd_data_q;
    ld_lo       = 1'b0;
    ld_hi       = 1'b0;
    adv         = 1'b0;

    if (hostRd) begin
      rd_data_d = '0;
      case (hostAddr)
        REG_ADDR_LO: rd_data_d = ptr[7:0];
        REG_ADDR_HI: begin
          rd_data_d[7]          = incr_sel;
          rd_data_d[ADDR_W-9:0] = ptr[ADDR_W-1:8];
        end
        REG_STATUS: begin
          rd_data_d[STAT_ERR]  = err_q;
          rd_data_d[STAT_BUSY] = busy_q;
        end
        default: rd_data_d = '0;
      endcase
    end

    err_d = (err_q && !(hostRd && hostAddr == REG_STATUS)) || (hostWr && state_q == ST_FILL);

    case (state_q)
      ST_IDLE: begin
        if (hostWr) begin
          case (hostAddr)
            REG_ADDR_LO: ld_lo = 1'b1;
            REG_ADDR_HI: ld_hi = 1'b1;
            REG_DATA: begin
              vram_wr_d   = 1'b1;
              vram_addr_d = ptr;
              vram_data_d = hostWrData;
              adv         = 1'b1;
            end
            REG_CNT_LO: fill_cnt_d[7:0]       = hostWrData;
            REG_CNT_HI: fill_cnt_d[CNT_W-1:8] = hostWrData[CNT_W-9:0];
            REG_FILL_GO: begin
              if (fill_cnt_q != '0) begin
                // First fill write is issued from IDLE so it lands the cycle after GO;
                // rem counts writes still to appear on the port, including this one.
                state_d     = ST_FILL;
                fill_val_d  = hostWrData;
                rem_d       = fill_cnt_q;
                vram_wr_d   = 1'b1;
                vram_addr_d = ptr;
                vram_data_d = hostWrData;
                adv         = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_FILL: begin
        if (rem_q > CNT_W'(1)) begin
          vram_wr_d   = 1'b1;
          vram_addr_d = ptr;
          vram_data_d = fill_val_q;
          adv         = 1'b1;
          rem_d       = rem_q - CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end
      end
    endcase

    busy_d = (state_d == ST_FILL);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fill_val_q  <= '0;
      rem_q       <= '0;
      fill_cnt_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      vram_wr_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      fill_val_q  <= fill_val_d;
      rem_q       <= rem_d;
      fill_cnt_q  <= fill_cnt_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      vram_wr_q   <= vram_wr_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign hostRdData = rd_data_q;
  assign vramWrAddr = vram_addr_q;
  assign vramWrData = vram_data_q;
  assign vramWr     = vram_wr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vram_host_port.sv
// Bench for vram_host_port: directed vector table plus randomized host traffic
// checked cycle by cycle against a transaction-level model of the register map.
module tb_vram_host_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hostAddr;
  logic [7:0]  hostWrData;
  logic        hostWr;
  logic        hostRd;
  logic [7:0]  hostRdData;
  logic [12:0] vramWrAddr;
  logic [7:0]  vramWrData;
  logic        vramWr;
  logic        busy;

  vram_host_port #(
    .ADDR_W   (13),
    .INCR_ALT (32),
    .CNT_W    (13)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hostAddr   (hostAddr),
    .hostWrData (hostWrData),
    .hostWr     (hostWr),
    .hostRd     (hostRd),
    .hostRdData (hostRdData),
    .vramWrAddr (vramWrAddr),
    .vramWrData (vramWrData),
    .vramWr     (vramWr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model state. Expectations are keyed by the cycle in which they are visible,
  // i.e. the value of cyc just after the posedge that produced them.
  int m_ptr = 0, m_incr_sel = 0, m_cnt = 0, m_err = 0;
  int fs = -10, fe = -10;
  int exp_wa[int];
  int exp_wd[int];
  int exp_rd[int];
  bit mon_en = 1'b0;
  int wlog[$];
  int wcyc[$];
  int busy_cnt = 0;

  function automatic bit m_busy(int c);
    return (c >= fs) && (c <= fe);
  endfunction

  // One host bus cycle: drive after a posedge, sampled by the DUT at the next one (s).
  task automatic op(input bit wr, input bit rd, input logic [2:0] a, input logic [7:0] d);
    int s;
    bit b;
    int inc;
    @(posedge clk);
    #1;
    hostWr = wr; hostRd = rd; hostAddr = a; hostWrData = d;
    s   = cyc + 1;
    b   = m_busy(s - 1);
    inc = m_incr_sel ? 32 : 1;
    if (rd) begin
      case (a)
        3'd0:    exp_rd[s] = m_ptr & 'hFF;
        3'd1:    exp_rd[s] = (m_incr_sel << 7) | (m_ptr >> 8);
        3'd7:    exp_rd[s] = (m_err << 1) | int'(b);
        default: exp_rd[s] = 0;
      endcase
    end
    m_err = int'((m_err != 0 && !(rd && a == 3'd7)) || (wr && b));
    if (wr && !b) begin
      case (a)
        3'd0: m_ptr = (m_ptr & 'h1F00) | int'(d);
        3'd1: begin
          m_ptr      = (m_ptr & 'hFF) | ((int'(d) & 'h1F) << 8);
          m_incr_sel = int'(d[7]);
        end
        3'd2: begin
          exp_wa[s] = m_ptr; exp_wd[s] = int'(d);
          m_ptr = (m_ptr + inc) % 8192;
        end
        3'd3: m_cnt = (m_cnt & 'h1F00) | int'(d);
        3'd4: m_cnt = (m_cnt & 'hFF) | ((int'(d) & 'h1F) << 8);
        3'd5: begin
          if (m_cnt != 0) begin
            for (int i = 0; i < m_cnt; i++) begin
              exp_wa[s+i] = m_ptr; exp_wd[s+i] = int'(d);
              m_ptr = (m_ptr + inc) % 8192;
            end
            fs = s;
            fe = s + m_cnt - 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic do_reset();
    int s;
    int ks[$];
    @(posedge clk);
    #1;
    rst = 1'b1; hostWr = 1'b0; hostRd = 1'b0;
    s = cyc + 1;
    m_ptr = 0; m_incr_sel = 0; m_cnt = 0; m_err = 0;
    if (fe > s - 1) fe = s - 1;
    foreach (exp_wa[k]) if (k >= s) ks.push_back(k);
    foreach (exp_rd[k]) if (k >= s && !exp_wa.exists(k)) ks.push_back(k);
    foreach (ks[j]) begin
      exp_wa.delete(ks[j]); exp_wd.delete(ks[j]); exp_rd.delete(ks[j]);
    end
    exp_rd[s] = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Per-cycle comparison of the write port, busy and read data against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_wa.exists(cyc)) begin
        check("vramWr", 32'(vramWr), 1);
        check("vramWrAddr", 32'(vramWrAddr), exp_wa[cyc]);
        check("vramWrData", 32'(vramWrData), exp_wd[cyc]);
        exp_wa.delete(cyc);
        exp_wd.delete(cyc);
      end else begin
        check("vramWr_idle", 32'(vramWr), 0);
      end
      check("busy", 32'(busy), 32'(m_busy(cyc)));
      if (exp_rd.exists(cyc)) begin
        check("hostRdData", 32'(hostRdData), exp_rd[cyc]);
        exp_rd.delete(cyc);
      end
      if (vramWr === 1'b1) begin
        wlog.push_back((int'(vramWrAddr) << 8) | int'(vramWrData));
        wcyc.push_back(cyc);
      end
      if (busy === 1'b1) busy_cnt++;
    end
  end

  typedef struct {
    bit         rst;
    bit         wr;
    bit         rd;
    logic [2:0] a;
    logic [7:0] d;
    int         n;
    bit         chk;
    logic [7:0] e;
  } vec_t;

  vec_t vq[$];

  function automatic void V(bit wr, bit rd, int a, int d, int n, bit chk, int e);
    vec_t t;
    t.rst = 1'b0; t.wr = wr; t.rd = rd; t.a = 3'(a); t.d = 8'(d);
    t.n = n; t.chk = chk; t.e = 8'(e);
    vq.push_back(t);
  endfunction
  function automatic void W(int a, int d);  V(1, 0, a, d, 1, 0, 0); endfunction
  function automatic void R(int a, int e);  V(0, 1, a, 0, 1, 1, e); endfunction
  function automatic void IDL(int n);       V(0, 0, 0, 0, n, 0, 0); endfunction
  function automatic void RST();
    vec_t t;
    t = '{rst: 1'b1, wr: 1'b0, rd: 1'b0, a: 3'd0, d: 8'd0, n: 1, chk: 1'b0, e: 8'd0};
    vq.push_back(t);
  endfunction

  task automatic run_table(input string tag);
    foreach (vq[i]) begin
      if (vq[i].rst) begin
        do_reset();
      end else begin
        for (int k = 0; k < vq[i].n; k++) op(vq[i].wr, vq[i].rd, vq[i].a, vq[i].d);
        if (vq[i].chk) begin
          op(1'b0, 1'b0, 3'd0, 8'd0);
          @(negedge clk);
          check($sformatf("%s_vec%0d_rd", tag, i), 32'(hostRdData), 32'(vq[i].e));
        end
      end
    end
    vq.delete();
  endtask

  function automatic int wl(int i);
    return (i < wlog.size()) ? wlog[i] : -1;
  endfunction

  task automatic clear_log();
    wlog.delete(); wcyc.delete(); busy_cnt = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n55;
    rst = 1'b1; hostWr = 1'b0; hostRd = 1'b0; hostAddr = 3'd0; hostWrData = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_hostRdData", 32'(hostRdData), 0);
    check("rst_vramWr", 32'(vramWr), 0);
    check("rst_vramWrAddr", 32'(vramWrAddr), 0);
    check("rst_vramWrData", 32'(vramWrData), 0);
    check("rst_busy", 32'(busy), 0);
    mon_en = 1'b1;

    // Data burst across the top of the address space.
    clear_log();
    W(1, 'h1F); W(0, 'hFE); W(2, 'hA1); W(2, 'hA2); W(2, 'hA3);
    R(0, 'h01); R(1, 'h00);
    run_table("burst");
    check("burst_count", wlog.size(), 3);
    check("burst_w0", wl(0), 'h1FFEA1);
    check("burst_w1", wl(1), 'h1FFFA2);
    check("burst_w2", wl(2), 'h0000A3);
    if (wcyc.size() == 3) check("burst_back_to_back", wcyc[2] - wcyc[0], 2);

    // Row-step fill.
    clear_log();
    W(1, 'h80); W(0, 'h00); W(3, 3); W(4, 0); W(5, 'h20); IDL(4);
    R(0, 'h60); R(1, 'h80);
    run_table("rowfill");
    check("rowfill_busy_cycles", busy_cnt, 3);
    check("rowfill_count", wlog.size(), 3);
    check("rowfill_w0", wl(0), 'h000020);
    check("rowfill_w1", wl(1), 'h002020);
    check("rowfill_w2", wl(2), 'h004020);

    // Zero-count GO.
    clear_log();
    W(3, 0); W(4, 0); W(5, 'h77); IDL(3); R(0, 'h60);
    run_table("zerogo");
    check("zerogo_writes", wlog.size(), 0);
    check("zerogo_busy", busy_cnt, 0);

    // Host write during a long fill is dropped and flagged.
    clear_log();
    W(1, 0); W(0, 0); W(3, 100); W(4, 0); W(5, 'h99); IDL(3); W(2, 'h55); IDL(100);
    R(7, 'h02); R(7, 'h00);
    run_table("wrfill");
    n55 = 0;
    foreach (wlog[i]) if ((wlog[i] & 'hFF) == 'h55) n55++;
    check("wrfill_count", wlog.size(), 100);
    check("wrfill_no55", n55, 0);
    check("wrfill_busy_cycles", busy_cnt, 100);

    // Reset in the middle of a fill.
    clear_log();
    W(3, 50); W(4, 0); W(5, 'h11); IDL(9); RST(); IDL(2);
    R(0, 0); R(1, 0); R(7, 0);
    run_table("rstfill");
    check("rstfill_count", wlog.size(), 10);

    // Simultaneous read and write of the same register.
    W(1, 0); W(0, 'h12);
    V(1, 1, 0, 'h34, 1, 1, 'h12);
    R(0, 'h34);
    run_table("rdwr");

    // Randomized traffic against the model.
    for (int k = 0; k < 800; k++) begin
      int r;
      logic [2:0] a;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom_range(0, 255));
      if (r == 0) begin
        do_reset();
      end else if (m_busy(cyc + 1)) begin
        case (r % 4)
          0:       op(1'b1, 1'b0, a, d);
          1:       op(1'b0, 1'b1, 3'd7, 8'd0);
          2:       op(1'b0, 1'b1, 3'($urandom_range(2, 6)), 8'd0);
          default: op(1'b0, 1'b0, 3'd0, 8'd0);
        endcase
      end else begin
        if (a == 3'd4) d = d & 8'hE0;
        op($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, d);
      end
    end
    for (int k = 0; k < 300; k++) op(1'b0, 1'b0, 3'd0, 8'd0);
    @(negedge clk);
    check("drain_writes", exp_wa.size(), 0);
    check("drain_reads", exp_rd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
